// File: rtl/text_console_writer_if.sv
// Character-stream handshake and VRAM word bus between the host-side character
// source, text_console_writer and the text-mode VRAM register file.
interface text_console_writer_if;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        inv_mode;
    logic [9:0]  vram_addr;
    logic [31:0] vram_wdata;
    logic [3:0]  vram_be;
    logic        vram_we;
    logic        vram_re;
    logic [31:0] vram_rdata;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    // The writer: consumes characters and masters the VRAM bus.
    modport master (
        input  char_data, char_valid, inv_mode, vram_rdata,
        output char_ready, vram_addr, vram_wdata, vram_be, vram_we, vram_re,
               cursor_col, cursor_row, busy
    );

    // The environment: character source plus VRAM register file.
    modport slave (
        output char_data, char_valid, inv_mode, vram_rdata,
        input  char_ready, vram_addr, vram_wdata, vram_be, vram_we, vram_re,
               cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// Character-stream writer for the 80x30 text-mode VRAM: places glyph bytes at
// the cursor, interprets BS/LF/FF/CR, scrolls up one row and clears the screen.
// Word 600 (control/colour register) lies outside every address it produces.
module text_console_writer #(
    parameter int         COLS = 80,
    parameter int         ROWS = 30,
    parameter int         WPR  = COLS / 4,
    parameter logic [7:0] FILL = 8'h20
) (
    input logic                   Clk,
    input logic                   Reset,
    text_console_writer_if.master bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WRITE     = 3'd1;
    localparam logic [2:0] ST_SCROLL_RD = 3'd2;
    localparam logic [2:0] ST_SCROLL_WR = 3'd3;
    localparam logic [2:0] ST_FILL      = 3'd4;

    localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
    localparam logic [9:0] ROW_WORDS = 10'(WPR);
    localparam logic [9:0] COPY_LAST = 10'((ROWS - 1) * WPR - 1);
    localparam logic [9:0] FILL_LAST = 10'(ROWS * WPR - 1);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    logic [2:0] state;
    logic [7:0] code;       // character latched at the handshake
    logic       inv;        // invert attribute latched with it
    logic [6:0] col;
    logic [4:0] row;
    logic [9:0] ptr;        // copy index during scroll, then fill address

    logic       printable;
    logic [7:0] glyph;
    logic [9:0] cell_addr;

    assign printable = (code >= 8'h20) && (code <= 8'h7E);
    assign glyph     = {inv, code[6:0]};
    assign cell_addr = 10'(row) * ROW_WORDS + 10'(col[6:2]);

    // Control FSM, cursor and scroll/fill pointer.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
            code  <= '0;
            inv   <= 1'b0;
            col   <= '0;
            row   <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.char_valid) begin
                        code  <= bus.char_data;
                        inv   <= bus.inv_mode;
                        state <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    state <= ST_IDLE;
                    if (printable) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            if (row == LAST_ROW) begin
                                ptr   <= '0;
                                state <= ST_SCROLL_RD;
                            end else begin
                                row <= row + 5'd1;
                            end
                        end else begin
                            col <= col + 7'd1;
                        end
                    end else begin
                        case (code)
                            CH_LF: begin
                                col <= '0;
                                if (row == LAST_ROW) begin
                                    ptr   <= '0;
                                    state <= ST_SCROLL_RD;
                                end else begin
                                    row <= row + 5'd1;
                                end
                            end
                            CH_CR: col <= '0;
                            CH_BS: if (col != '0) col <= col - 7'd1;
                            CH_FF: begin
                                col   <= '0;
                                row   <= '0;
                                ptr   <= '0;
                                state <= ST_FILL;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_SCROLL_RD: state <= ST_SCROLL_WR;

                ST_SCROLL_WR: begin
                    // The pointer runs straight on into the bottom-row fill.
                    ptr   <= ptr + 10'd1;
                    state <= (ptr == COPY_LAST) ? ST_FILL : ST_SCROLL_RD;
                end

                ST_FILL: begin
                    if (ptr == FILL_LAST) begin
                        ptr   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        ptr <= ptr + 10'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    // VRAM strobes decoded from the state; all held low while Reset is high.
    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        bus.vram_we    = 1'b0;
        bus.vram_re    = 1'b0;
        bus.vram_be    = 4'h0;
        bus.vram_addr  = '0;
        bus.vram_wdata = '0;
        if (!Reset) begin
            case (state)
                ST_WRITE: begin
                    if (printable) begin
                        bus.vram_we    = 1'b1;
                        bus.vram_addr  = cell_addr;
                        bus.vram_be    = 4'b0001 << col[1:0];
                        bus.vram_wdata = {4{glyph}};
                    end
                end
                ST_SCROLL_RD: begin
                    bus.vram_re   = 1'b1;
                    bus.vram_addr = ptr + ROW_WORDS;
                end
                ST_SCROLL_WR: begin
                    bus.vram_we    = 1'b1;
                    bus.vram_addr  = ptr;
                    bus.vram_be    = 4'hF;
                    bus.vram_wdata = bus.vram_rdata;
                end
                ST_FILL: begin
                    bus.vram_we    = 1'b1;
                    bus.vram_addr  = ptr;
                    bus.vram_be    = 4'hF;
                    bus.vram_wdata = {4{FILL}};
                end
                default: ;
            endcase
        end
    end

    assign bus.char_ready = (state == ST_IDLE) && !Reset;
    assign bus.busy       = !Reset && ((state == ST_SCROLL_RD) ||
                                       (state == ST_SCROLL_WR) ||
                                       (state == ST_FILL));
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: screen-level reference model,
// a VRAM register file, and one per-cycle compare process.
module tb_text_console_writer;

    localparam int          COLS     = 80;
    localparam int          ROWS     = 30;
    localparam int          WPR      = COLS / 4;
    localparam int          NWORDS   = ROWS * WPR;
    localparam logic [31:0] SENTINEL = 32'hDEADBEEF;
    localparam logic [31:0] BLANKS   = 32'h20202020;

    typedef struct {
        bit         print;
        int         kind;       // 0 none, 1 scroll, 2 clear
        int         addr;
        logic [3:0] be;
        logic [7:0] glyph;
        int         col;
        int         row;
        int         busy;
        int         writes;
        int         reads;
    } op_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    text_console_writer_if bus ();

    text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // VRAM register file (words 0..600, 600 = control register)
    logic [31:0] mem [0:NWORDS];
    logic [31:0] rdata_q;
    int          preload_mode;   // 1: zeros, 2: word n = n
    assign bus.vram_rdata = rdata_q;

    // Reference model state
    logic [31:0] exp_mem [0:NWORDS-1];
    int          m_col, m_row;

    // Current transaction seen by the compare process
    op_t cur_op;
    bit  op_pending = 1'b0;
    int  since, op_w, op_r, op_b, k;
    int  last_w_addr, last_writes, last_busy, last_lat;
    logic [3:0]  last_w_be;
    logic [31:0] last_w_data;
    int  tot_w = 0;
    bit  hit600 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // VRAM register file behaviour: byte-enabled writes, registered reads.
    always @(posedge clk) begin
        if (preload_mode != 0) begin
            for (int n = 0; n < NWORDS; n++)
                mem[n] <= (preload_mode == 2) ? 32'(n) : 32'h0;
            mem[NWORDS] <= SENTINEL;
        end else begin
            if (bus.vram_we && bus.vram_addr <= 10'(NWORDS))
                for (int b = 0; b < 4; b++)
                    if (bus.vram_be[b])
                        mem[bus.vram_addr][8*b +: 8] <= bus.vram_wdata[8*b +: 8];
            if (bus.vram_re)
                rdata_q <= (bus.vram_addr <= 10'(NWORDS)) ? mem[bus.vram_addr] : 32'hBADBAD00;
        end
    end

    // Screen-level model: apply one character, return what the DUT must do.
    task automatic model_apply(input logic [7:0] code, input logic inv, output op_t o);
        o.print = 1'b0; o.kind = 0; o.addr = 0; o.be = 4'h0; o.glyph = 8'h0;
        if (code >= 8'h20 && code <= 8'h7E) begin
            o.print = 1'b1;
            o.addr  = m_row * WPR + m_col / 4;
            o.be    = 4'b0001 << (m_col % 4);
            o.glyph = {inv, code[6:0]};
            exp_mem[o.addr][8*(m_col%4) +: 8] = o.glyph;
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                if (m_row == ROWS - 1) o.kind = 1; else m_row++;
            end
        end else begin
            case (code)
                8'h0A: begin
                    m_col = 0;
                    if (m_row == ROWS - 1) o.kind = 1; else m_row++;
                end
                8'h0D: m_col = 0;
                8'h08: if (m_col > 0) m_col--;
                8'h0C: begin o.kind = 2; m_col = 0; m_row = 0; end
                default: ;
            endcase
        end
        if (o.kind == 1) begin
            for (int i = 0; i < (ROWS-1)*WPR; i++) exp_mem[i] = exp_mem[i+WPR];
            for (int i = (ROWS-1)*WPR; i < NWORDS; i++) exp_mem[i] = BLANKS;
        end else if (o.kind == 2) begin
            for (int i = 0; i < NWORDS; i++) exp_mem[i] = BLANKS;
        end
        o.col    = m_col;
        o.row    = m_row;
        o.busy   = (o.kind == 1) ? 2*(ROWS-1)*WPR + WPR : (o.kind == 2) ? NWORDS : 0;
        o.writes = (o.print ? 1 : 0) + ((o.kind != 0) ? NWORDS : 0);
        o.reads  = (o.kind == 1) ? (ROWS-1)*WPR : 0;
    endtask

    // Compare process: invariants every cycle, transaction checks against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("reset_quiet", {28'b0, bus.vram_we, bus.vram_re, bus.busy, bus.char_ready}, 32'h0);
        end else begin
            check("we_re_exclusive", 32'(bus.vram_we & bus.vram_re), 32'h0);
            if (bus.vram_we || bus.vram_re) begin
                check("addr_in_range", 32'(bus.vram_addr < 10'(NWORDS)), 32'h1);
                if (bus.vram_addr == 10'(NWORDS)) hit600 = 1'b1;
            end
            if (bus.char_ready)
                check("idle_quiet", {29'b0, bus.vram_we, bus.vram_re, bus.busy}, 32'h0);
            if (bus.vram_we) tot_w++;
            if (op_pending) begin
                since++;
                if (since == 1) begin
                    if (cur_op.print) begin
                        check("glyph_we",    32'(bus.vram_we),   32'h1);
                        check("glyph_addr",  32'(bus.vram_addr), cur_op.addr);
                        check("glyph_be",    32'(bus.vram_be),   32'(cur_op.be));
                        check("glyph_wdata", bus.vram_wdata,     {4{cur_op.glyph}});
                    end else begin
                        check("ctrl_no_strobe", {30'b0, bus.vram_we, bus.vram_re}, 32'h0);
                    end
                end else if (!bus.char_ready) begin
                    check("busy_during_op", 32'(bus.busy), 32'h1);
                    if (bus.vram_re)
                        check("scroll_rd_addr", 32'(bus.vram_addr), op_r + WPR);
                    if (bus.vram_we) begin
                        k = op_w - (cur_op.print ? 1 : 0);
                        check("bulk_wr_addr", 32'(bus.vram_addr), k);
                        check("bulk_wr_be",   32'(bus.vram_be),   32'hF);
                        if (cur_op.kind == 2 || k >= (ROWS-1)*WPR)
                            check("fill_wdata", bus.vram_wdata, BLANKS);
                    end
                end
                if (bus.vram_we) begin
                    op_w++;
                    last_w_addr = 32'(bus.vram_addr);
                    last_w_be   = bus.vram_be;
                    last_w_data = bus.vram_wdata;
                end
                if (bus.vram_re) op_r++;
                if (bus.busy)    op_b++;
                if (since >= 2 && bus.char_ready) begin
                    check("latency",        since, 2 + cur_op.busy);
                    check("op_writes",      op_w,  cur_op.writes);
                    check("op_reads",       op_r,  cur_op.reads);
                    check("op_busy_cycles", op_b,  cur_op.busy);
                    check("cursor_col",     32'(bus.cursor_col), cur_op.col);
                    check("cursor_row",     32'(bus.cursor_row), cur_op.row);
                    last_writes = op_w;
                    last_busy   = op_b;
                    last_lat    = since;
                    op_pending  = 1'b0;
                end
            end
        end
    end

    // Offer one character; valid is held until the DUT takes it.
    task automatic send(input logic [7:0] code, input logic inv);
        op_t  o;
        logic rdy;
        int   n = 0;
        model_apply(code, inv, o);
        @(negedge clk);
        bus.char_data  = code;
        bus.inv_mode   = inv;
        bus.char_valid = 1'b1;
        forever begin
            rdy = bus.char_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 5000) begin
                check("accept_timeout", 32'h0, 32'h1);
                bus.char_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        #1;
        cur_op = o;
        since = 0; op_w = 0; op_r = 0; op_b = 0;
        op_pending     = 1'b1;
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (op_pending && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (op_pending) begin
            check("done_timeout", 32'h0, 32'h1);
            op_pending = 1'b0;
        end
        #1;
    endtask

    function automatic int mem_bad(input int skip);
        int b = 0;
        for (int i = 0; i < NWORDS; i++)
            if (i != skip && mem[i] !== exp_mem[i]) b++;
        return b;
    endfunction

    task automatic check_cursor(input string name, input int c, input int r);
        check({name, "_col"}, 32'(bus.cursor_col), c);
        check({name, "_row"}, 32'(bus.cursor_row), r);
    endtask

    logic [31:0] saved [0:NWORDS-1];
    logic [7:0]  others [6] = '{8'h00, 8'h07, 8'h1B, 8'h7F, 8'h9A, 8'hC1};

    initial begin
        int t0, bad, r;
        logic [7:0] c;
        reset = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h0;
        bus.inv_mode   = 1'b0;
        preload_mode   = 1;
        for (int i = 0; i < NWORDS; i++) exp_mem[i] = 32'h0;
        m_col = 0; m_row = 0;
        repeat (3) @(negedge clk);
        preload_mode = 0;
        reset = 1'b0;
        #1;
        check("reset_ready", 32'(bus.char_ready), 32'h1);
        check("reset_busy",  32'(bus.busy),       32'h0);
        check_cursor("reset_cursor", 0, 0);

        // 'A' at (0,0)
        send(8'h41, 1'b0);
        wait_done();
        check("a_writes", last_writes, 1);
        check("a_addr",   last_w_addr, 0);
        check("a_be",     32'(last_w_be), 32'h1);
        check("a_byte",   32'(last_w_data[7:0]), 32'h41);
        check("a_latency", last_lat, 2);
        check_cursor("a_cursor", 1, 0);

        // Move to (6,2), then inverted 'B'
        send(8'h0A, 1'b0); send(8'h0A, 1'b0);
        for (int i = 0; i < 6; i++) send(8'h61 + 8'(i), 1'b0);
        send(8'h42, 1'b1);
        wait_done();
        check("b_addr", last_w_addr, 41);
        check("b_be",   32'(last_w_be), 32'h4);
        check("b_byte", 32'(last_w_data[23:16]), 32'hC2);
        check_cursor("b_cursor", 7, 2);

        // Full row from (0,0), back to back
        send(8'h0C, 1'b0);
        wait_done();
        t0 = tot_w;
        for (int i = 0; i < COLS; i++) send(8'h20 + 8'(i % 95), 1'(i % 2));
        wait_done();
        check("row_writes",    tot_w - t0, 80);
        check("row_last_addr", last_w_addr, 19);
        check("row_last_be",   32'(last_w_be), 32'h8);
        check_cursor("row_cursor", 0, 1);

        // Scroll from (5,29) over a word-index pattern
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) send(8'h58, 1'b0);
        wait_done();
        check_cursor("pre_scroll_cursor", 5, 29);
        @(negedge clk);
        preload_mode = 2;
        for (int i = 0; i < NWORDS; i++) exp_mem[i] = 32'(i);
        @(posedge clk);
        #1 preload_mode = 0;
        send(8'h0A, 1'b0);
        wait_done();
        check("scroll_busy", last_busy, 1180);
        bad = 0;
        for (int i = 0; i < 580; i++) if (mem[i] !== 32'(i + 20)) bad++;
        check("scroll_shifted_words", bad, 0);
        bad = 0;
        for (int i = 580; i < NWORDS; i++) if (mem[i] !== BLANKS) bad++;
        check("scroll_blank_words", bad, 0);
        check("ctrl_word_untouched", mem[NWORDS], SENTINEL);
        check("ctrl_word_addressed", 32'(hit600), 32'h0);
        check_cursor("scroll_cursor", 0, 29);
        check("scroll_model_words", mem_bad(-1), 0);

        // Clear screen, then BS at column 0 and BEL
        t0 = tot_w;
        send(8'h0C, 1'b0);
        wait_done();
        check("ff_writes",    tot_w - t0, 600);
        check("ff_last_addr", last_w_addr, 599);
        check_cursor("ff_cursor", 0, 0);
        check("ff_model_words", mem_bad(-1), 0);
        send(8'h08, 1'b0);
        wait_done();
        check("bs_writes", last_writes, 0);
        check_cursor("bs_cursor", 0, 0);
        send(8'h07, 1'b0);
        wait_done();
        check("bel_writes", last_writes, 0);
        check_cursor("bel_cursor", 0, 0);

        // Reset in the middle of a scroll copy (SCROLL_WR, n = 100)
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 1'b0);
        wait_done();
        for (int i = 0; i < NWORDS; i++) saved[i] = exp_mem[i];
        send(8'h0A, 1'b0);
        r = 0;
        do begin
            @(negedge clk);
            r++;
        end while (!(bus.vram_we && bus.vram_addr == 10'd100) && r < 3000);
        check("reach_copy_100", 32'(r < 3000), 32'h1);
        #1;
        reset = 1'b1;
        op_pending = 1'b0;
        @(negedge clk);
        #1;
        check("mid_reset_we",   32'(bus.vram_we), 32'h0);
        check("mid_reset_re",   32'(bus.vram_re), 32'h0);
        check("mid_reset_busy", 32'(bus.busy),    32'h0);
        check_cursor("mid_reset_cursor", 0, 0);
        reset = 1'b0;
        #1;
        check("post_reset_ready", 32'(bus.char_ready), 32'h1);
        for (int i = 0; i < 100; i++) exp_mem[i] = saved[i + WPR];
        for (int i = 100; i < NWORDS; i++) exp_mem[i] = saved[i];
        m_col = 0; m_row = 0;
        check("partial_scroll_words", mem_bad(100), 0);
        send(8'h0C, 1'b0);
        wait_done();

        // Randomized character stream
        for (int i = 0; i < 260; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      c = 8'($urandom_range(32, 126));
            else if (r < 82) c = 8'h0A;
            else if (r < 87) c = 8'h0D;
            else if (r < 93) c = 8'h08;
            else if (r < 98) c = others[$urandom_range(0, 5)];
            else             c = 8'h0C;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            send(c, 1'($urandom_range(0, 1)));
        end
        wait_done();
        check("random_model_words", mem_bad(-1), 0);
        check_cursor("random_cursor", m_col, m_row);
        check("final_ctrl_word", mem[NWORDS], SENTINEL);
        check("final_ctrl_addressed", 32'(hit600), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Character-stream writer for the 80x30 text-mode VRAM that the HDMI text colour mapper scans out.
- Accepts one 8-bit character per valid/ready handshake and writes its glyph byte into the correct VRAM word and byte lane. It maintains a cursor, interprets a small set of control codes, scrolls the screen up one row and clears the screen.
- Sits between the host-side character source (MicroBlaze/AXI shim or UART receiver) and the VRAM register file.
- Never touches the control/colour register at word 600.

Parameters:
- COLS, 80, characters per row; a multiple of 4.
- ROWS, 30, character rows.
- WPR, COLS/4, 32-bit VRAM words per row (20).
- FILL, 8'h20, glyph code written by clear and scroll fill.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- char_data  in  8  incoming character code.
- char_valid  in  1  char_data valid.
- char_ready  out  1  writer can accept; a transfer occurs on a Clk edge with valid&ready.
- inv_mode  in  1  invert attribute, sampled with the accepted character.
- vram_addr  out  10  VRAM word address, 0..599.
- vram_wdata  out  32  write data.
- vram_be  out  4  byte enables; be[k] selects bits [8k+7:8k].
- vram_we  out  1  write strobe, one cycle per word.
- vram_re  out  1  read strobe; vram_rdata is valid the following cycle.
- vram_rdata  in  32  read data.
- cursor_col  out  7  current column, 0..COLS-1.
- cursor_row  out  5  current row, 0..ROWS-1.
- busy  out  1  high in SCROLL_RD, SCROLL_WR, FILL.

Behaviour:
- Glyph byte = {inv, code[6:0]}. Cell (c,r) maps to word r*WPR + c/4, lane c%4 (lane 0 = bits [7:0]).
- States: IDLE, WRITE, SCROLL_RD, SCROLL_WR, FILL.
- char_ready = (state==IDLE) && !Reset.
- Reset (any state, including mid-scroll or mid-fill):
  - Next state IDLE; cursor (0,0).
  - vram_we/vram_re/vram_be/vram_addr/vram_wdata = 0; busy = 0.
  - VRAM contents are left as-is (a partial scroll is not undone or completed).
- Transfer in IDLE: latch code and inv_mode, go to WRITE. The following cycle (WRITE) acts by code class.
- Printable (0x20..0x7E):
  - Assert vram_we with addr = word(cursor), be = one-hot lane, glyph byte replicated on all four lanes.
  - Advance col. If col==COLS-1: col→0 and row+1. If row==ROWS-1: go to SCROLL_RD with cursor (0,ROWS-1).
- 0x0A LF: col→0. If row<ROWS-1, row+1 and return to IDLE; else go to SCROLL_RD, cursor (0,ROWS-1).
- 0x0D CR: col→0. Return to IDLE.
- 0x08 BS: col-1 if col>0, else unchanged. No write; no reverse line wrap.
- 0x0C FF: go to FILL over all ROWS*WPR words; cursor (0,0).
- Any other code: consumed with no write and no cursor change.
- Without scroll or fill, accept-to-ready is exactly 2 cycles, giving sustained throughput of 1 char / 2 cycles.
- Scroll copies words n = 0..(ROWS-1)*WPR-1:
  - SCROLL_RD: vram_re=1, addr = n+WPR.
  - SCROLL_WR: vram_we=1, addr = n, be = 4'hF, wdata = vram_rdata.
  - After the last copy, FILL words (ROWS-1)*WPR..ROWS*WPR-1.
  - Default-geometry cost: 1160 copy cycles + 20 fill cycles.
- FILL: one word per cycle, wdata = {4{FILL}}, be = 4'hF, ascending addresses. Return to IDLE the cycle after the last fill write.
- Never: vram_we and vram_re together; any address ≥ ROWS*WPR; any strobe in IDLE.
- char_valid held while busy is neither accepted nor lost; it transfers on the first IDLE edge.

Test Plan:
- Reset, then send 0x41 with inv=0 → exactly one vram_we cycle, addr 0, be 4'b0001, wdata[7:0]=0x41; cursor (1,0); char_ready high 2 cycles after accept.
- Cursor (6,2), send 0x42 with inv=1 → addr 41, be 4'b0100, wdata[23:16]=0xC2; cursor (7,2).
- 80 printables from (0,0) → 80 writes, the last at addr 19 with be 4'b1000; cursor (0,1); no scroll.
- Preload word n = n for all n, cursor (5,29), send 0x0A:
  - busy for 1180 cycles.
  - Final words 0..579 = n+20; words 580..599 = 0x20202020.
  - Cursor (0,29); word 600 never addressed.
- Send 0x0C → 600 consecutive writes of 0x20202020, be 4'hF, addr 0..599; cursor (0,0). Then send 0x08 at col 0 and 0x07 → no writes, cursor unchanged.
- Assert Reset during SCROLL_WR at n=100 → next cycle vram_we=vram_re=0, busy=0, cursor (0,0); char_ready=1 the cycle after Reset deasserts.
